// File: rtl/edsac_order_pkg.sv
// rtl/edsac_order_pkg.sv - EDSAC order codes, control-line indices and sequencer types
package edsac_order_pkg;

  localparam int OP_W_DEF = 5;

  localparam logic [OP_W_DEF-1:0] OP_P     = 5'd0;
  localparam logic [OP_W_DEF-1:0] OP_Q     = 5'd1;
  localparam logic [OP_W_DEF-1:0] OP_W     = 5'd2;
  localparam logic [OP_W_DEF-1:0] OP_E     = 5'd3;
  localparam logic [OP_W_DEF-1:0] OP_R     = 5'd4;
  localparam logic [OP_W_DEF-1:0] OP_T     = 5'd5;
  localparam logic [OP_W_DEF-1:0] OP_Y     = 5'd6;
  localparam logic [OP_W_DEF-1:0] OP_U     = 5'd7;
  localparam logic [OP_W_DEF-1:0] OP_I     = 5'd8;
  localparam logic [OP_W_DEF-1:0] OP_O     = 5'd9;
  localparam logic [OP_W_DEF-1:0] OP_J     = 5'd10;
  localparam logic [OP_W_DEF-1:0] OP_PI    = 5'd11;
  localparam logic [OP_W_DEF-1:0] OP_S     = 5'd12;
  localparam logic [OP_W_DEF-1:0] OP_Z     = 5'd13;
  localparam logic [OP_W_DEF-1:0] OP_K     = 5'd14;
  localparam logic [OP_W_DEF-1:0] OP_STAR  = 5'd15;
  localparam logic [OP_W_DEF-1:0] OP_DOT   = 5'd16;
  localparam logic [OP_W_DEF-1:0] OP_F     = 5'd17;
  localparam logic [OP_W_DEF-1:0] OP_THETA = 5'd18;
  localparam logic [OP_W_DEF-1:0] OP_D     = 5'd19;
  localparam logic [OP_W_DEF-1:0] OP_PHI   = 5'd20;
  localparam logic [OP_W_DEF-1:0] OP_H     = 5'd21;
  localparam logic [OP_W_DEF-1:0] OP_N     = 5'd22;
  localparam logic [OP_W_DEF-1:0] OP_M     = 5'd23;
  localparam logic [OP_W_DEF-1:0] OP_DELTA = 5'd24;
  localparam logic [OP_W_DEF-1:0] OP_L     = 5'd25;
  localparam logic [OP_W_DEF-1:0] OP_X     = 5'd26;
  localparam logic [OP_W_DEF-1:0] OP_G     = 5'd27;
  localparam logic [OP_W_DEF-1:0] OP_A     = 5'd28;
  localparam logic [OP_W_DEF-1:0] OP_B     = 5'd29;
  localparam logic [OP_W_DEF-1:0] OP_C     = 5'd30;
  localparam logic [OP_W_DEF-1:0] OP_V     = 5'd31;

  localparam int C_ADD       = 1;
  localparam int C_SUB       = 2;
  localparam int C_MULT_H    = 3;
  localparam int C_MULT_V    = 4;
  localparam int C_MULT_N    = 5;
  localparam int C_STORE_T   = 6;
  localparam int C_STORE_U   = 7;
  localparam int C_COLLATE   = 8;
  localparam int C_SHIFT_R   = 9;
  localparam int C_SHIFT_L   = 10;
  localparam int C_BRANCH_E  = 11;
  localparam int C_BRANCH_G  = 12;
  localparam int C_INPUT     = 13;
  localparam int C_OUTPUT    = 14;
  localparam int C_VERIFY    = 16;
  localparam int C_ROUND_X   = 17;
  localparam int C_ROUND_Y   = 18;
  localparam int C_STOP      = 19;
  localparam int C_CLEAR_ACC = 20;
  localparam int C_STORE_WR  = 24;
  localparam int C_TRANSFER  = 25;

  typedef enum logic [1:0] {
    ST_HALT,
    ST_FETCH,
    ST_EXEC
  } seq_state_e;

  typedef enum logic [2:0] {
    CLS_SIMPLE,
    CLS_SHIFT,
    CLS_MULT,
    CLS_BR_E,
    CLS_BR_G,
    CLS_STOP
  } order_class_e;

endpackage

// File: rtl/order_decode_rom.sv
// rtl/order_decode_rom.sv - combinational order code to control vector, class and legality
module order_decode_rom
  import edsac_order_pkg::*;
#(
  parameter int OP_W   = OP_W_DEF,
  parameter int N_CTRL = 28
) (
  input  logic [OP_W-1:0]   order_code,
  output logic [N_CTRL-1:0] ctrl,
  output order_class_e      cls,
  output logic              legal
);

  always_comb begin
    ctrl  = '0;
    cls   = CLS_SIMPLE;
    legal = 1'b1;
    case (order_code)
      OP_A: ctrl[C_ADD] = 1'b1;
      OP_S: ctrl[C_SUB] = 1'b1;
      OP_H: begin ctrl[C_MULT_H] = 1'b1; cls = CLS_MULT; end
      OP_V: begin ctrl[C_MULT_V] = 1'b1; cls = CLS_MULT; end
      OP_N: begin ctrl[C_MULT_N] = 1'b1; cls = CLS_MULT; end
      OP_T: begin
        ctrl[C_STORE_T]   = 1'b1;
        ctrl[C_CLEAR_ACC] = 1'b1;
        ctrl[C_STORE_WR]  = 1'b1;
      end
      OP_U: begin ctrl[C_STORE_U] = 1'b1; ctrl[C_STORE_WR] = 1'b1; end
      OP_C: begin ctrl[C_COLLATE] = 1'b1; ctrl[C_CLEAR_ACC] = 1'b1; end
      OP_R: begin ctrl[C_SHIFT_R] = 1'b1; cls = CLS_SHIFT; end
      OP_L: begin ctrl[C_SHIFT_L] = 1'b1; cls = CLS_SHIFT; end
      OP_E: begin ctrl[C_BRANCH_E] = 1'b1; cls = CLS_BR_E; end
      OP_G: begin ctrl[C_BRANCH_G] = 1'b1; cls = CLS_BR_G; end
      OP_I: begin ctrl[C_INPUT] = 1'b1; ctrl[C_STORE_WR] = 1'b1; end
      OP_O: ctrl[C_OUTPUT]  = 1'b1;
      OP_F: ctrl[C_VERIFY]  = 1'b1;
      OP_X: ctrl[C_ROUND_X] = 1'b1;
      OP_Y: ctrl[C_ROUND_Y] = 1'b1;
      OP_Z: begin ctrl[C_STOP] = 1'b1; cls = CLS_STOP; end
      OP_P, OP_Q, OP_W, OP_J, OP_PI, OP_K, OP_STAR, OP_DOT,
      OP_THETA, OP_D, OP_PHI, OP_M, OP_DELTA, OP_B: legal = 1'b0;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/order_sequencer.sv
// rtl/order_sequencer.sv - fetch/execute sequencer with registered control-line vector
module order_sequencer
  import edsac_order_pkg::*;
#(
  parameter int OP_W    = OP_W_DEF,
  parameter int N_CTRL  = 28,
  parameter int CNT_W   = 5,
  parameter int MULT_MC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mc_start,
  input  logic              order_valid,
  output logic              order_ready,
  input  logic [OP_W-1:0]   order_code,
  input  logic [CNT_W-1:0]  order_cnt,
  input  logic              acc_neg,
  input  logic              starter,
  output logic [N_CTRL-1:0] ctrl,
  output logic              stage2,
  output logic              transfer_taken,
  output logic              halted,
  output logic              illegal
);

  seq_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_load;
  logic [N_CTRL-1:0] rom_ctrl, exec_ctrl;
  order_class_e      rom_cls;
  logic              rom_legal;
  logic              accept, enters_exec, last_mc, branch_taken;

  order_decode_rom #(.OP_W(OP_W), .N_CTRL(N_CTRL)) u_rom (
    .order_code (order_code),
    .ctrl       (rom_ctrl),
    .cls        (rom_cls),
    .legal      (rom_legal)
  );

  assign accept      = (state == ST_FETCH) && mc_start && order_valid;
  assign enters_exec = accept && rom_legal && (rom_cls != CLS_STOP);
  // Treat a zero count as terminal too, so EXEC can never stall.
  assign last_mc     = (state == ST_EXEC) && mc_start && (cnt <= CNT_W'(1));

  always_comb begin
    branch_taken = 1'b0;
    if (rom_cls == CLS_BR_E) branch_taken = !acc_neg;
    if (rom_cls == CLS_BR_G) branch_taken = acc_neg;
  end

  always_comb begin
    exec_ctrl = rom_ctrl;
    if (branch_taken) exec_ctrl[C_TRANSFER] = 1'b1;
  end

  always_comb begin
    cnt_load = CNT_W'(1);
    case (rom_cls)
      CLS_SHIFT: cnt_load = (order_cnt == '0) ? CNT_W'(1) : order_cnt;
      CLS_MULT:  cnt_load = CNT_W'(MULT_MC);
      default:   cnt_load = CNT_W'(1);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_HALT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (mc_start) begin
      case (state)
        ST_HALT:  if (starter) state_nxt = ST_FETCH;
        ST_FETCH: begin
          if (order_valid) begin
            if (!rom_legal || rom_cls == CLS_STOP) state_nxt = ST_HALT;
            else                                   state_nxt = ST_EXEC;
          end
        end
        ST_EXEC:  if (cnt <= CNT_W'(1)) state_nxt = ST_FETCH;
        default:  state_nxt = ST_HALT;
      endcase
    end
  end

  always_comb begin
    order_ready = (state == ST_FETCH) && mc_start;
    halted      = (state == ST_HALT);
    stage2      = (state == ST_EXEC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl           <= '0;
      cnt            <= '0;
      transfer_taken <= 1'b0;
      illegal        <= 1'b0;
    end else begin
      transfer_taken <= 1'b0;
      if (state == ST_HALT && mc_start && starter) illegal <= 1'b0;
      if (accept && !rom_legal) illegal <= 1'b1;
      if (enters_exec) begin
        ctrl           <= exec_ctrl;
        cnt            <= cnt_load;
        transfer_taken <= branch_taken;
      end else if (last_mc) begin
        ctrl <= '0;
        cnt  <= '0;
      end else if (state == ST_EXEC && mc_start) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_order_sequencer.sv
// tb/tb_order_sequencer.sv - scoreboard bench for order_sequencer
module tb_order_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mc_start;
  logic        order_valid;
  logic        order_ready;
  logic [4:0]  order_code;
  logic [4:0]  order_cnt;
  logic        acc_neg;
  logic        starter;
  logic [27:0] ctrl;
  logic        stage2;
  logic        transfer_taken;
  logic        halted;
  logic        illegal;

  typedef struct {
    logic        is_pulse;
    logic [27:0] ctrl;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  mc_phase = 0;

  order_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mc_start       (mc_start),
    .order_valid    (order_valid),
    .order_ready    (order_ready),
    .order_code     (order_code),
    .order_cnt      (order_cnt),
    .acc_neg        (acc_neg),
    .starter        (starter),
    .ctrl           (ctrl),
    .stage2         (stage2),
    .transfer_taken (transfer_taken),
    .halted         (halted),
    .illegal        (illegal)
  );

  always #5 clk = ~clk;

  // Minor cycle of four digit clocks; mc_start changes just after the rising edge.
  initial begin
    mc_start = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mc_phase = (mc_phase + 1) % 4;
      mc_start = (mc_phase == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got %h want %h", name, act, exp);
  endtask

  task automatic observe(input logic p, input logic [27:0] c);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event got pulse=%0d ctrl=%h want none", p, c);
    end else begin
      e = exp_q.pop_front();
      if (e.is_pulse == p && (p || e.ctrl == c)) n_pass++;
      else $display("FAIL exec_event got pulse=%0d ctrl=%h want pulse=%0d ctrl=%h",
                    p, c, e.is_pulse, e.ctrl);
    end
  endtask

  // Monitor: one event per branch pulse and one per execute minor cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (transfer_taken) observe(1'b1, '0);
      if (mc_start && stage2) observe(1'b0, ctrl);
    end
  end

  task automatic push_exec(input logic [27:0] c, input int n, input bit pulse);
    ev_t e;
    if (pulse) begin
      e.is_pulse = 1'b1; e.ctrl = '0;
      exp_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      e.is_pulse = 1'b0; e.ctrl = c;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_mc();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mc_start) return;
    end
    n_checks++;
    $display("FAIL wait_mc timeout got no mc_start want mc_start");
  endtask

  task automatic issue(input logic [4:0] code, input logic [4:0] cnt, input logic neg);
    bit got;
    got = 1'b0;
    order_code = code; order_cnt = cnt; acc_neg = neg; order_valid = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (mc_start && order_ready) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL issue_timeout code=%0d got no order_ready want order_ready", code);
    end
    @(posedge clk);
    #1;
    order_valid = 1'b0;
  endtask

  task automatic press_starter();
    starter = 1'b1;
    wait_mc();
    @(posedge clk);
    #1;
    starter = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; order_valid = 1'b0; order_code = '0; order_cnt = '0;
    acc_neg = 1'b0; starter = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_halted", halted, 1);
    check("rst_ctrl", ctrl, 0);
    check("rst_stage2", stage2, 0);
    check("rst_illegal", illegal, 0);
    check("rst_transfer", transfer_taken, 0);
    check("rst_ready", order_ready, 0);
    rst_n = 1'b1;

    press_starter();
    check("start_halted", halted, 0);

    push_exec(28'h0000002, 1, 0); issue(5'd28, 5'd0, 1'b0);   // A
    push_exec(28'h0000200, 6, 0); issue(5'd4,  5'd6, 1'b0);   // R, 6
    push_exec(28'h0000400, 1, 0); issue(5'd25, 5'd0, 1'b0);   // L, 0 -> 1
    push_exec(28'h2000800, 1, 1); issue(5'd3,  5'd0, 1'b0);   // E taken
    push_exec(28'h0001000, 1, 0); issue(5'd27, 5'd0, 1'b0);   // G not taken
    push_exec(28'h2001000, 1, 1); issue(5'd27, 5'd0, 1'b1);   // G taken
    push_exec(28'h0000010, 4, 0); issue(5'd31, 5'd0, 1'b0);   // V
    push_exec(28'h1100040, 1, 0); issue(5'd5,  5'd0, 1'b0);   // T
    issue(5'd13, 5'd0, 1'b0);                                 // Z

    wait_mc();
    check("stop_halted", halted, 1);
    check("stop_ctrl", ctrl, 0);
    check("stop_stage2", stage2, 0);
    order_code = 5'd28; order_valid = 1'b1;
    wait_mc();
    check("stop_ready_1", order_ready, 0);
    wait_mc();
    check("stop_ready_2", order_ready, 0);
    @(posedge clk); #1;
    order_valid = 1'b0;
    press_starter();
    check("restart_halted", halted, 0);

    issue(5'd0, 5'd0, 1'b0);                                  // P undefined
    check("illegal_set", illegal, 1);
    check("illegal_halted", halted, 1);
    check("illegal_ctrl", ctrl, 0);
    starter = 1'b1;
    wait_mc();
    check("illegal_held", illegal, 1);
    @(posedge clk); #1;
    starter = 1'b0;
    check("illegal_cleared", illegal, 0);
    check("illegal_restart", halted, 0);

    push_exec(28'h0000200, 3, 0); issue(5'd4, 5'd10, 1'b0);  // R, 10, cut by reset
    repeat (3) wait_mc();
    #1;
    check("mid_exec_ctrl", ctrl, 32'h0000200);
    check("mid_exec_stage2", stage2, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", ctrl, 0);
    check("async_rst_stage2", stage2, 0);
    check("async_rst_halted", halted, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_halted", halted, 1);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/order_sequencer.md
Name: order_sequencer

Overview:
- Parametrised successor to the combinational order coder.
- Latches a 5-bit EDSAC order code at a minor-cycle boundary and decodes it into a registered control-line vector.
- Sequences the fetch/execute stages, including multi-minor-cycle orders (shifts, multiplies), conditional transfers and stop/start.
- Sits between the order tank read-out and the arithmetic/store control in the control section.

Parameters:
- OP_W, 5, order code width in bits.
- N_CTRL, 28, width of the control vector; bit i drives control line c(i); bit 0 is unused.
- CNT_W, 5, width of the shift-count field taken from the order address bits.
- MULT_MC, 4, number of execute minor cycles for H/V/N orders (minimum 1).

Ports:
- clk  in  1  system clock (digit clock).
- rst_n  in  1  asynchronous active-low reset.
- mc_start  in  1  one-clock pulse marking the first digit of each minor cycle.
- order_valid  in  1  order_code/order_cnt hold a fetched order.
- order_ready  out  1  sequencer accepts the order at this mc_start.
- order_code  in  OP_W  teleprinter code of the order.
- order_cnt  in  CNT_W  shift amount for L/R; ignored for other orders.
- acc_neg  in  1  accumulator sign; sampled at the accepting mc_start.
- starter  in  1  start button, level; sampled on mc_start.
- ctrl  out  N_CTRL  registered control lines, valid for whole execute minor cycles.
- stage2  out  1  1 during execute minor cycles, 0 during fetch.
- transfer_taken  out  1  one-clock pulse when E/G branches.
- halted  out  1  sequencer is stopped.
- illegal  out  1  sticky; set on an undefined code, cleared by starter.

Behaviour:
- Reset (async, rst_n=0): state=HALT, ctrl=0, stage2=0, transfer_taken=0, halted=1, illegal=0, order_ready=0, counter=0.
- States: HALT, FETCH, EXEC. All transitions occur only on the clock where mc_start=1.
- HALT -> FETCH when starter=1 at mc_start. That transition also clears illegal.
- FETCH:
  - order_ready=1 combinationally while in FETCH and mc_start=1.
  - Handshake completes when order_valid=1 on that clock. order_code, order_cnt and acc_neg are latched.
  - If order_valid=0, remain in FETCH with no side effects.
- Decode at acceptance sets the execute-cycle count N:
  - L/R: N = max(1, order_cnt).
  - H/V/N: N = MULT_MC.
  - All other orders: N = 1.
- EXEC:
  - From the accept clock+1, ctrl = decoded vector and stage2=1.
  - Both are held for exactly N minor cycles, then drop to 0 on the clock of the Nth following mc_start, in the same cycle as the return to FETCH.
  - The counter decrements on each mc_start in EXEC.
- Decoded lines (package table):
  - A->c1, S->c2, H->c3, V->c4, N->c5, T->c6, U->c7, C->c8, R->c9, L->c10, E->c11, G->c12, I->c13, O->c14, F->c16, X->c17, Y->c18, Z->c19.
  - c20 (clear accumulator) is asserted with T and with C.
  - c24 (store write) is asserted with T, U and I.
- E: transfer if acc_neg=0. G: transfer if acc_neg=1.
  - The branch decision uses acc_neg latched at accept.
  - If taken, c25 is asserted and transfer_taken pulses on the first EXEC clock.
- Z: no EXEC stage; the accept clock enters HALT with halted=1.
- Undefined codes (P, Q, W, J, π, K, *, ., θ, D, φ, M, Δ, B): set illegal=1 and enter HALT. ctrl stays 0.
- starter=1 outside HALT is ignored.
- mc_start coincident with reset: reset wins.
- Reset mid-EXEC clears ctrl immediately (async). No partial order is resumed.
- Counter arithmetic is unsigned CNT_W-bit. order_cnt=0 is treated as 1 for L/R. Maximum L/R length is 2^CNT_W-1 minor cycles.

Decomposition:
- Package edsac_order_pkg:
  - OP_W-bit localparams for all 32 teleprinter codes (P=0 … A=28, B=29, C=30, V=31).
  - Control-line index constants (C_ADD=1, …, C_TRANSFER=25).
  - State enum {HALT, FETCH, EXEC}.
- Sub-module order_decode_rom: purely combinational code -> {ctrl vector, class, legal}, reused by the sequencer.
- FSM and counter stay in order_sequencer.

Test Plan:
- Start-up: after reset, starter=1 at mc_start, then A (28) offered -> halted falls; order_ready asserts at the next mc_start; ctrl[1]=1, stage2=1 for exactly 1 minor cycle.
- Shift: R (4) with order_cnt=6 -> ctrl[9]=1 for 6 consecutive minor cycles, then FETCH.
- Shift with order_cnt=0: L (25) -> ctrl[10] held for 1 minor cycle.
- Conditional transfer: E (3) with acc_neg=0 -> transfer_taken pulses once and ctrl[11], ctrl[25] are set. G (27) with acc_neg=0 -> ctrl[12] set, ctrl[25]=0, no pulse.
- Multiply and stop: V (31) -> ctrl[4] held MULT_MC=4 minor cycles. Then Z (13) -> halted=1, ctrl=0, and orders are ignored until starter.
- Error and reset: code 0 (P) -> illegal=1 and halted=1; starter clears illegal. Separately, rst_n pulled low mid-EXEC of R with order_cnt=10 -> ctrl=0 immediately, state HALT.
